// File: rtl/icache_control_update_pkg.sv
// Shared types and widths for the icache per-set replacement/valid controller.
package icache_control_update_pkg;

    localparam int unsigned WAYS   = 4;
    localparam int unsigned WAY_W  = 2;
    localparam int unsigned PLRU_W = 3;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_INVD   = 2'd3
    } state_t;

    // Control word as stored in the control ram: {plru[2:0], valid[3:0]}.
    typedef struct packed {
        logic [PLRU_W-1:0] plru;
        logic [WAYS-1:0]   valid;
    } ctrl_word_t;

endpackage

// File: rtl/icache_plru.sv
// Tree pLRU helper for one 4-way set.
//  plru_i      current tree bits {p2,p1,p0}
//  valid_i     per-way valid bits
//  way_i       way being touched (hit way or filled way)
//  victim_o    lowest invalid way, else the way the tree points at
//  plru_next_o tree bits after touching way_i
module icache_plru
    import icache_control_update_pkg::*;
(
    input  logic [PLRU_W-1:0] plru_i,
    input  logic [WAYS-1:0]   valid_i,
    input  logic [WAY_W-1:0]  way_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [PLRU_W-1:0] plru_next_o
);

    // Victim: an empty way is always preferred over evicting a live line.
    always_comb begin
        victim_o = 2'd0;
        if (!valid_i[0])      victim_o = 2'd0;
        else if (!valid_i[1]) victim_o = 2'd1;
        else if (!valid_i[2]) victim_o = 2'd2;
        else if (!valid_i[3]) victim_o = 2'd3;
        else if (!plru_i[0])  victim_o = plru_i[1] ? 2'd1 : 2'd0;
        else                  victim_o = plru_i[2] ? 2'd3 : 2'd2;
    end

    // Touch: point every tree node on the path away from the touched way.
    always_comb begin
        plru_next_o    = plru_i;
        plru_next_o[0] = ~way_i[1];
        if (!way_i[1]) plru_next_o[1] = ~way_i[0];
        else           plru_next_o[2] = ~way_i[0];
    end

endmodule

// File: rtl/icache_control_update.sv
// Per-set replacement/valid controller for the 4-way icache. Reads the control
// word for the fetched set, resolves hit way or victim way, writes back pLRU
// and valid bits, and sequences a full-cache invalidate through the control ram.
//  lookup_do/lookup_address  lookup request (IDLE only); set = address[11:4]
//  tag_hit                   per-way tag match, valid the cycle after accept
//  lookup_done/hit/way       1-cycle result pulse
//  fill_done                 victim line fill complete
//  invd_do/invd_done         full invalidate request and completion pulse
//  ctrl_*                    control ram read/write/invalidate port
module icache_control_update
    import icache_control_update_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_do,
    input  logic [ADDR_W-1:0] lookup_address,
    input  logic [WAYS-1:0]   tag_hit,
    output logic              lookup_done,
    output logic              lookup_hit,
    output logic [WAY_W-1:0]  lookup_way,
    input  logic              fill_done,
    input  logic              invd_do,
    output logic              invd_done,
    output logic [ADDR_W-1:0] ctrl_address,
    output logic              ctrl_read_do,
    input  logic [CTRL_W-1:0] ctrl_q,
    output logic              ctrl_write_do,
    output logic [CTRL_W-1:0] ctrl_data,
    output logic              ctrl_invdcode_do,
    input  logic              ctrl_invdcode_done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    ctrl_word_t        word_q, word_d;
    logic [WAY_W-1:0]  way_q, way_d;

    ctrl_word_t        rd_word;
    logic [WAYS-1:0]   hitvec;
    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic [PLRU_W-1:0] plru_in;
    logic [WAYS-1:0]   valid_in;
    logic [WAY_W-1:0]  way_in;
    logic [WAY_W-1:0]  victim;
    logic [PLRU_W-1:0] plru_next;

    assign rd_word = ctrl_word_t'(ctrl_q);
    assign hitvec  = tag_hit & rd_word.valid;
    assign hit_any = |hitvec;

    // Multiple hits cannot be resolved meaningfully; lowest way wins.
    always_comb begin
        hit_way = 2'd0;
        if (hitvec[0])      hit_way = 2'd0;
        else if (hitvec[1]) hit_way = 2'd1;
        else if (hitvec[2]) hit_way = 2'd2;
        else if (hitvec[3]) hit_way = 2'd3;
    end

    // One pLRU unit: FILL updates the saved word, otherwise the word just read.
    always_comb begin
        if (state_q == ST_FILL) begin
            plru_in  = word_q.plru;
            valid_in = word_q.valid;
            way_in   = way_q;
        end else begin
            plru_in  = rd_word.plru;
            valid_in = rd_word.valid;
            way_in   = hit_way;
        end
    end

    icache_plru u_plru (
        .plru_i      (plru_in),
        .valid_i     (valid_in),
        .way_i       (way_in),
        .victim_o    (victim),
        .plru_next_o (plru_next)
    );

    // State and captured-lookup registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            way_q   <= way_d;
        end
    end

    // Next state; invalidate wins over a simultaneous lookup.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        way_d   = way_q;
        unique case (state_q)
            ST_IDLE: begin
                if (invd_do) begin
                    state_d = ST_INVD;
                end else if (lookup_do) begin
                    addr_d  = lookup_address;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    state_d = ST_IDLE;
                end else begin
                    word_d  = rd_word;
                    way_d   = victim;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: if (fill_done) state_d = ST_IDLE;
            ST_INVD: if (ctrl_invdcode_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs; the ram sees the live fetch address only while a lookup can be accepted.
    always_comb begin
        lookup_done      = 1'b0;
        lookup_hit       = 1'b0;
        lookup_way       = 2'd0;
        invd_done        = 1'b0;
        ctrl_read_do     = 1'b0;
        ctrl_write_do    = 1'b0;
        ctrl_data        = '0;
        ctrl_invdcode_do = 1'b0;
        ctrl_address     = (state_q == ST_IDLE) ? lookup_address : addr_q;
        unique case (state_q)
            ST_IDLE: ctrl_read_do = lookup_do & ~invd_do;
            ST_LOOKUP: begin
                lookup_done = 1'b1;
                lookup_hit  = hit_any;
                lookup_way  = hit_any ? hit_way : victim;
                if (hit_any) begin
                    ctrl_write_do = 1'b1;
                    ctrl_data     = {plru_next, rd_word.valid};
                end
            end
            ST_FILL: begin
                if (fill_done) begin
                    ctrl_write_do = 1'b1;
                    ctrl_data     = {plru_next, word_q.valid | (WAYS'(1) << way_q)};
                end
            end
            ST_INVD: begin
                ctrl_invdcode_do = 1'b1;
                invd_done        = ctrl_invdcode_done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_control_update.sv
// Bench for icache_control_update: directed scenarios plus randomized lookups
// checked against a behavioural tree-pLRU model.
module tb_icache_control_update;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_do;
    logic [31:0] lookup_address;
    logic [3:0]  tag_hit;
    logic        lookup_done;
    logic        lookup_hit;
    logic [1:0]  lookup_way;
    logic        fill_done;
    logic        invd_do;
    logic        invd_done;
    logic [31:0] ctrl_address;
    logic        ctrl_read_do;
    logic [6:0]  ctrl_q;
    logic        ctrl_write_do;
    logic [6:0]  ctrl_data;
    logic        ctrl_invdcode_do;
    logic        ctrl_invdcode_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_control_update dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lookup_do          (lookup_do),
        .lookup_address     (lookup_address),
        .tag_hit            (tag_hit),
        .lookup_done        (lookup_done),
        .lookup_hit         (lookup_hit),
        .lookup_way         (lookup_way),
        .fill_done          (fill_done),
        .invd_do            (invd_do),
        .invd_done          (invd_done),
        .ctrl_address       (ctrl_address),
        .ctrl_read_do       (ctrl_read_do),
        .ctrl_q             (ctrl_q),
        .ctrl_write_do      (ctrl_write_do),
        .ctrl_data          (ctrl_data),
        .ctrl_invdcode_do   (ctrl_invdcode_do),
        .ctrl_invdcode_done (ctrl_invdcode_done)
    );

    // ---------------- reference model ----------------
    // Ways as leaves of a binary tree: p0 picks the half, p1/p2 pick within it.
    function automatic logic [1:0] m_victim(input logic [6:0] w);
        logic [2:0] p;
        p = w[6:4];
        for (int i = 0; i < 4; i++)
            if (!w[i]) return 2'(i);
        if (p[0] == 1'b0) return p[1] ? 2'd1 : 2'd0;
        return p[2] ? 2'd3 : 2'd2;
    endfunction

    // After touching a way, the tree must lead away from it.
    function automatic logic [2:0] m_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        int         wi;
        r  = p;
        wi = int'(w);
        r[0] = (wi < 2);
        if (wi < 2) r[1] = (wi == 0);
        else        r[2] = (wi == 2);
        return r;
    endfunction

    // ---------------- stimulus helpers (drive + sample only) ----------------
    task automatic drive_idle();
        @(negedge clk);
        lookup_do = 1'b0; invd_do = 1'b0; fill_done = 1'b0; ctrl_invdcode_done = 1'b0;
        tag_hit = 4'd0; ctrl_q = 7'd0;
    endtask

    task automatic drive_accept(input logic [31:0] a, output logic rd, output logic [31:0] ad);
        @(negedge clk);
        lookup_do = 1'b1; lookup_address = a; invd_do = 1'b0; fill_done = 1'b0;
        ctrl_invdcode_done = 1'b0;
        #1;
        rd = ctrl_read_do;
        ad = ctrl_address;
    endtask

    task automatic drive_lookup(input logic [6:0] q, input logic [3:0] t,
                                output logic done, output logic hit, output logic [1:0] way,
                                output logic wr, output logic [6:0] data, output logic rd);
        @(negedge clk);
        lookup_do = 1'b0; invd_do = 1'b0; fill_done = 1'b0;
        ctrl_q = q; tag_hit = t;
        #1;
        done = lookup_done; hit = lookup_hit; way = lookup_way;
        wr = ctrl_write_do; data = ctrl_data; rd = ctrl_read_do;
    endtask

    task automatic drive_fill(output logic wr, output logic [6:0] data, output logic [31:0] ad);
        @(negedge clk);
        lookup_do = 1'b0; invd_do = 1'b0; fill_done = 1'b1;
        ctrl_q = 7'd0; tag_hit = 4'd0;
        #1;
        wr = ctrl_write_do; data = ctrl_data; ad = ctrl_address;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [46:0] outs;
        rst_n = 1'b0;
        lookup_do = 1'b0; lookup_address = 32'd0; tag_hit = 4'd0; fill_done = 1'b0;
        invd_do = 1'b0; ctrl_q = 7'd0; ctrl_invdcode_done = 1'b0;
        #2;
        outs = {lookup_done, lookup_hit, lookup_way, invd_done, ctrl_address, ctrl_read_do,
                ctrl_write_do, ctrl_data, ctrl_invdcode_do};
        n_checks++;
        if (outs !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_miss();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        drive_accept(32'h0000_1230, rd, ad);
        n_checks++;
        if (rd !== 1'b1 || ad !== 32'h0000_1230) begin
            n_fail++;
            $display("FAIL first_accept: read_do=%b addr=%h want 1/00001230", rd, ad);
        end
        drive_lookup(7'd0, 4'd0, done, hit, way, wr, data, rd2);
        n_checks++;
        if (done !== 1'b1 || hit !== 1'b0 || way !== 2'd0 || wr !== 1'b0 || rd2 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_miss: done=%b hit=%b way=%0d wr=%b rd=%b want 1/0/0/0/0",
                     done, hit, way, wr, rd2);
        end
        drive_fill(wr, data, ad);
        n_checks++;
        if (wr !== 1'b1 || data !== 7'b011_0001 || ad[11:4] !== 8'h23) begin
            n_fail++;
            $display("FAIL first_fill: wr=%b data=%b set=%h want 1/0110001/23", wr, data, ad[11:4]);
        end
        drive_idle();
    endtask

    task automatic test_hit();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        drive_accept(32'h0000_4560, rd, ad);
        drive_lookup(7'b000_1111, 4'b0100, done, hit, way, wr, data, rd2);
        // Touching way 2 sets p0=0 (left half next) and p2=1 (way 3 next on the right).
        n_checks++;
        if (done !== 1'b1 || hit !== 1'b1 || way !== 2'd2 || wr !== 1'b1 ||
            data !== 7'b100_1111 || rd2 !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_way2: done=%b hit=%b way=%0d wr=%b data=%b rd=%b want 1/1/2/1/1001111/0",
                     done, hit, way, wr, data, rd2);
        end
        drive_idle();
        #1;
        n_checks++;
        if (lookup_done !== 1'b0 || ctrl_write_do !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_pulse_width: done=%b wr=%b want 0/0", lookup_done, ctrl_write_do);
        end
    endtask

    task automatic test_plru_victim();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        drive_accept(32'h0000_0FF0, rd, ad);
        drive_lookup(7'b010_1111, 4'b0000, done, hit, way, wr, data, rd2);
        n_checks++;
        if (done !== 1'b1 || hit !== 1'b0 || way !== 2'd1 || wr !== 1'b0) begin
            n_fail++;
            $display("FAIL plru_victim: done=%b hit=%b way=%0d wr=%b want 1/0/1/0", done, hit, way, wr);
        end
        drive_fill(wr, data, ad);
        // Filling way 1 sets p0=1 and clears p1 (way 0 next within the left half).
        n_checks++;
        if (wr !== 1'b1 || data !== 7'b001_1111 || ad !== 32'h0000_0FF0) begin
            n_fail++;
            $display("FAIL plru_fill: wr=%b data=%b addr=%h want 1/0011111/00000ff0", wr, data, ad);
        end
        drive_idle();
    endtask

    task automatic test_invalid_pref();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        drive_accept(32'h0000_0040, rd, ad);
        drive_lookup(7'b000_1011, 4'b0000, done, hit, way, wr, data, rd2);
        n_checks++;
        if (done !== 1'b1 || hit !== 1'b0 || way !== 2'd2) begin
            n_fail++;
            $display("FAIL invalid_pref: done=%b hit=%b way=%0d want 1/0/2", done, hit, way);
        end
        // A tag match on an invalid way is still a miss.
        drive_fill(wr, data, ad);
        drive_accept(32'h0000_0050, rd, ad);
        drive_lookup(7'b000_0111, 4'b1000, done, hit, way, wr, data, rd2);
        n_checks++;
        if (hit !== 1'b0 || way !== 2'd3 || wr !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_on_invalid: hit=%b way=%0d wr=%b want 0/3/0", hit, way, wr);
        end
        drive_fill(wr, data, ad);
        drive_idle();
    endtask

    task automatic test_fill_ignores();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        int bad;
        bad = 0;
        drive_accept(32'h0000_0AB0, rd, ad);
        drive_lookup(7'b000_0000, 4'b1111, done, hit, way, wr, data, rd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lookup_do = 1'b1; invd_do = 1'b1; lookup_address = 32'h0000_0CD0; fill_done = 1'b0;
            #1;
            if (ctrl_read_do || ctrl_write_do || ctrl_invdcode_do || lookup_done ||
                ctrl_address !== 32'h0000_0AB0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fill_wait_quiet: %0d noisy cycles want 0", bad);
        end
        drive_fill(wr, data, ad);
        n_checks++;
        if (wr !== 1'b1 || data !== 7'b011_0001) begin
            n_fail++;
            $display("FAIL fill_after_wait: wr=%b data=%b want 1/0110001", wr, data);
        end
        drive_idle();
    endtask

    task automatic test_invd();
        int pulses, lvl_bad;
        pulses = 0; lvl_bad = 0;
        @(negedge clk);
        invd_do = 1'b1; lookup_do = 1'b1; lookup_address = 32'h0000_0120;
        #1;
        n_checks++;
        if (ctrl_read_do !== 1'b0) begin
            n_fail++;
            $display("FAIL invd_no_read: read_do=%b want 0", ctrl_read_do);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            invd_do = 1'b0; lookup_do = 1'b0;
            #1;
            if (ctrl_invdcode_do !== 1'b1 || ctrl_read_do !== 1'b0) lvl_bad++;
            if (invd_done) pulses++;
        end
        n_checks++;
        if (lvl_bad != 0) begin
            n_fail++;
            $display("FAIL invd_level: %0d cycles without invdcode_do want 0", lvl_bad);
        end
        @(negedge clk);
        ctrl_invdcode_done = 1'b1;
        #1;
        if (invd_done) pulses++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ctrl_invdcode_done = 1'b0;
            #1;
            if (invd_done) pulses++;
            if (ctrl_invdcode_do) lvl_bad++;
        end
        n_checks++;
        if (pulses != 1 || lvl_bad != 0) begin
            n_fail++;
            $display("FAIL invd_done_once: pulses=%0d late_level=%0d want 1/0", pulses, lvl_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            drive_accept(32'(i) << 4, rd, ad);
            if (rd !== 1'b1) bad++;
            drive_lookup(7'b000_1111, 4'(1) << i, done, hit, way, wr, data, rd2);
            if (done !== 1'b1 || hit !== 1'b1 || way !== 2'(i) || wr !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL back_to_back: %0d bad transactions want 0", bad);
        end
        drive_idle();
    endtask

    task automatic test_reset_in_fill();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way;
        logic [6:0] data;
        logic [31:0] ad;
        logic [46:0] outs;
        drive_accept(32'h0000_0770, rd, ad);
        drive_lookup(7'b000_0001, 4'b0000, done, hit, way, wr, data, rd2);
        @(negedge clk);
        lookup_address = 32'd0; fill_done = 1'b1; ctrl_q = 7'd0;
        rst_n = 1'b0;
        #1;
        outs = {lookup_done, lookup_hit, lookup_way, invd_done, ctrl_address, ctrl_read_do,
                ctrl_write_do, ctrl_data, ctrl_invdcode_do};
        n_checks++;
        if (outs !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_in_fill: outputs %h want 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ctrl_write_do !== 1'b0) begin
            n_fail++;
            $display("FAIL no_write_after_reset: wr=%b want 0", ctrl_write_do);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic rd, done, hit, wr, rd2;
        logic [1:0] way, exp_way;
        logic [6:0] data, q, exp_data;
        logic [3:0] t, hv;
        logic [31:0] a, ad;
        logic exp_hit;
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            q = 7'($urandom);
            t = ($urandom_range(0, 1) == 0) ? 4'(1) << $urandom_range(0, 3) : 4'($urandom);
            hv = t & q[3:0];
            exp_hit = (hv != 4'd0);
            exp_way = 2'd0;
            if (exp_hit) begin
                for (int i = 3; i >= 0; i--) if (hv[i]) exp_way = 2'(i);
                exp_data = {m_touch(q[6:4], exp_way), q[3:0]};
            end else begin
                exp_way  = m_victim(q);
                exp_data = {m_touch(q[6:4], exp_way), q[3:0] | (4'(1) << exp_way)};
            end
            drive_accept(a, rd, ad);
            n_checks++;
            if (rd !== 1'b1 || ad !== a) begin
                n_fail++;
                $display("FAIL rnd_accept[%0d]: rd=%b addr=%h want 1/%h", n, rd, ad, a);
            end
            drive_lookup(q, t, done, hit, way, wr, data, rd2);
            n_checks++;
            if (done !== 1'b1 || hit !== exp_hit || way !== exp_way || wr !== exp_hit || rd2 !== 1'b0 ||
                (exp_hit && data !== exp_data)) begin
                n_fail++;
                $display("FAIL rnd_lookup[%0d]: q=%b t=%b hit=%b way=%0d wr=%b data=%b want %b/%0d/%b/%b",
                         n, q, t, hit, way, wr, data, exp_hit, exp_way, exp_hit, exp_data);
            end
            if (!exp_hit) begin
                repeat ($urandom_range(0, 2)) drive_idle_fill_wait();
                drive_fill(wr, data, ad);
                n_checks++;
                if (wr !== 1'b1 || data !== exp_data || ad !== a) begin
                    n_fail++;
                    $display("FAIL rnd_fill[%0d]: wr=%b data=%b addr=%h want 1/%b/%h",
                             n, wr, data, ad, exp_data, a);
                end
            end
        end
        drive_idle();
    endtask

    // Idle cycle inside FILL with the ram output changing underneath.
    task automatic drive_idle_fill_wait();
        @(negedge clk);
        lookup_do = 1'b0; invd_do = 1'b0; fill_done = 1'b0;
        ctrl_q = 7'($urandom); tag_hit = 4'($urandom);
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_plru_victim();
        test_invalid_pref();
        test_fill_ignores();
        test_invd();
        test_back_to_back();
        test_reset_in_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
